// File: rtl/alu_defs.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes, FSM
// state encoding and default datapath widths.
package alu_defs;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTR_W  = 4;

  localparam logic [ALU_CTR_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CTR_W-1:0] ALU_SUB = 4'b1000;
  localparam logic [ALU_CTR_W-1:0] ALU_SLL = 4'b0001;
  localparam logic [ALU_CTR_W-1:0] ALU_SRL = 4'b0101;
  localparam logic [ALU_CTR_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_CTR_W-1:0] ALU_OR  = 4'b0110;
  localparam logic [ALU_CTR_W-1:0] ALU_AND = 4'b0111;
  localparam logic [ALU_CTR_W-1:0] ALU_SLT = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two request channels and one tagged response channel around the shared ALU.
// master = requesters/consumer side, slave = arbiter side.
interface alu_share_arbiter_if
  import alu_defs::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CTR_W  = ALU_CTR_W
) ();
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [CTR_W-1:0]  req0_ctr;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [CTR_W-1:0]  req1_ctr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_less;
  logic              rsp_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctr,
    output req1_valid, req1_a, req1_b, req1_ctr,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_less, rsp_zero,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctr,
    input  req1_valid, req1_a, req1_b, req1_ctr,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_less, rsp_zero,
    input  rsp_ready
  );
endinterface

// File: rtl/alu.sv
// Existing combinational ALU shared by the arbiter. Less is the signed A<B
// compare, Zero flags an all-zero result.
module alu
  import alu_defs::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CTR_W  = ALU_CTR_W
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [CTR_W-1:0]  ALUctr,
  output logic [DATA_W-1:0] ALUout,
  output logic              Less,
  output logic              Zero
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = B[SH_W-1:0];
  assign Less  = $signed(A) < $signed(B);

  always_comb begin
    ALUout = '0;
    case (ALUctr)
      ALU_ADD: ALUout = A + B;
      ALU_SUB: ALUout = A - B;
      ALU_SLL: ALUout = A << shamt;
      ALU_SRL: ALUout = A >> shamt;
      ALU_XOR: ALUout = A ^ B;
      ALU_OR:  ALUout = A | B;
      ALU_AND: ALUout = A & B;
      ALU_SLT: ALUout = {{(DATA_W-1){1'b0}}, Less};
      default: ALUout = '0;
    endcase
  end

  assign Zero = (ALUout == '0);
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that did not win last time. One-hot (or zero) grant.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);
  always_comb begin
    grant_o = req_i;
    if (&req_i) grant_o = last_grant_i ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional accept counters are built when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter
  import alu_defs::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CTR_W  = ALU_CTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1
`endif
);
  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        grant;
  logic              accept;

  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [CTR_W-1:0]  op_ctr_q;
  logic              op_id_q;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_less_q, rsp_less_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic [DATA_W-1:0] alu_out;
  logic              alu_less, alu_zero;

  rr_arb2 u_arb (
    .req_i        ({bus.req1_valid, bus.req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign bus.req0_ready = (state_q == ST_IDLE) & grant[0];
  assign bus.req1_ready = (state_q == ST_IDLE) & grant[1];
  assign accept         = bus.req0_ready | bus.req1_ready;

  // Operands only change on accept, so the ALU inputs stay quiet between ops.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_q   <= grant[1] ? bus.req1_a   : bus.req0_a;
      op_b_q   <= grant[1] ? bus.req1_b   : bus.req0_b;
      op_ctr_q <= grant[1] ? bus.req1_ctr : bus.req0_ctr;
      op_id_q  <= grant[1];
    end
  end

  alu #(.DATA_W(DATA_W), .CTR_W(CTR_W)) u_alu (
    .A      (op_a_q),
    .B      (op_b_q),
    .ALUctr (op_ctr_q),
    .ALUout (alu_out),
    .Less   (alu_less),
    .Zero   (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_less_d   = rsp_less_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_grant_d = grant[1];
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = op_id_q;
        rsp_result_d = alu_out;
        rsp_less_d   = alu_less;
        rsp_zero_d   = alu_zero;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_less_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_less_q   <= rsp_less_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_less   = rsp_less_q;
  assign bus.rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] perf0_q, perf1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf0_q <= '0;
      perf1_q <= '0;
    end else begin
      if (bus.req0_ready) perf0_q <= sat_inc16(perf0_q);
      if (bus.req1_ready) perf1_q <= sat_inc16(perf1_q);
    end
  end

  assign perf_grant0 = perf0_q;
  assign perf_grant1 = perf1_q;
`endif
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the existing combinational ALU (ports A, B, ALUctr, ALUout, Less, Zero) between two requesters, for example an integer pipe and an address-generation or debug unit.
- Uses a round-robin arbiter, latched operands, a registered result and a single tagged response channel.
- Sits between the requesters and the ALU. It is the only driver of the ALU inputs.

Parameters:
- DATA_W, 32: operand and result width. It must match the ALU width.
- CTR_W, 4: width of the ALU control code.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  DATA_W  operand A.
- req0_b  in  DATA_W  operand B.
- req0_ctr  in  CTR_W  ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctr: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that owns the result (0 or 1).
- rsp_result  out  DATA_W  registered ALUout.
- rsp_less  out  1  registered Less.
- rsp_zero  out  1  registered Zero.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_less=0, rsp_zero=0, last_grant=1 (requester 0 wins the first tie).
- reqN_ready is combinational and is 1 only when state==IDLE, reqN_valid=1 and reqN is granted. At most one ready is high per cycle.
- Grant rule in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: requester !last_grant is granted.
  - Neither valid: stay in IDLE.
- IDLE, on accept: latch a, b, ctr and id; set last_grant = id; go to EXEC.
- EXEC: the ALU is driven from the latched registers. Capture ALUout, Less and Zero into the rsp_* registers, set rsp_valid=1, go to RESP.
- RESP: hold rsp_valid and all rsp_* stable until rsp_ready=1. On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
- Latency:
  - Accept in cycle N; rsp_valid is first high in cycle N+2.
  - Best-case throughput is one operation per 3 cycles (rsp_ready tied high).
  - No new request is accepted until the response completes.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is legal; no operation is issued.
- Control codes are passed through unchecked. Encodings: add 0000, sub 1000, sll 0001, srl 0101, xor 0100, or 0110, and 0111, slt 0010. The result for any other code is whatever the ALU produces.
- Back-pressure of any length is allowed in RESP; grant fairness is unaffected.
- A requester that re-asserts valid in the cycle its response completes is arbitrated normally in the next IDLE cycle.
- Reset low in any state, on the next edge:
  - state goes to IDLE and rsp_valid to 0;
  - the in-flight operation is discarded with no response;
  - last_grant returns to 1.
- Between transactions, the ALU inputs hold the last latched values; there is no toggling in IDLE.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined: adds two outputs, perf_grant0 and perf_grant1, each 16 bits.
  - Each counts accepts for its requester and saturates at 16'hFFFF.
  - Both are cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_defs holds:
  - the ALU control-code constants ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_XOR, ALU_OR, ALU_AND, ALU_SLT;
  - the FSM state encoding;
  - DATA_W and CTR_W defaults.
- Sub-module rr_arb2: a two-way round-robin grant with inputs req[1:0] and last_grant, and a one-hot grant output. Combinational, and reusable by other shared resources.
- The existing ALU is instantiated unchanged.

Test Plan:
- Single request, add: req0 a=10, b=5, ctr=0000 → req0_ready pulses once; 2 cycles later rsp_valid=1, id=0, result=15, less=0, zero=0.
- Contention right after reset: req0 sub 10-5 and req1 and 15&10 raised in the same cycle → first response id=0 result=5; second response id=1 result=10 (4'b1010). With both held valid, grants alternate 0,1,0,1.
- Back-pressure: req1 sll a=1, b=2 with rsp_ready=0 for 5 cycles → rsp_valid stays 1, result=4 stays stable, req0_ready stays 0 throughout; completes on the first rsp_ready=1.
- Flags:
  - slt a=5, b=10 → result=1, less=1.
  - add a=0, b=0 → result=0, zero=1.
  - srl a=16, b=2 → result=4.
  - xor 15^10 → result=5.
  - or 15|10 → result=15.
- Reset mid-operation: drop rst_n during EXEC → next cycle rsp_valid=0, state IDLE; that operation never responds. After release, simultaneous requests grant requester 0 first.
- With ALU_ARB_PERF_EN: 3 req0 operations and 2 req1 operations → perf_grant0=3, perf_grant1=2. Force-start perf_grant0 at 16'hFFFF, then one accept → it stays at 16'hFFFF.
